pipe_ialu: RTL and testbench

Integer ALU of the SCR1 execute stage. The main ALU is combinational and covers add/sub, logic, shifts and compares. It also drives a comparison flag to the EXU, and a separate address adder computes load/store/branch target addresses. An optional RV32M unit adds multiply (single cycle) and iterative divide (multi-cycle), both with a valid/ready handshake to the EXU.

---
 rtl/pipe_ialu.sv | 183 ++++++++++++++++++
 tb/tb_pipe_ialu.sv | 270 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/pipe_ialu.sv
// Integer ALU for the execute stage: combinational main ALU, compare flag and address adder.
// Define SCR1_IALU_RVM_EN to add the RV32M single-cycle multiplier and iterative restoring divider.
module pipe_ialu #(
  parameter int XLEN = 32
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            exu2ialu_rvm_cmd_vd_i,
  output logic            ialu2exu_rvm_res_rdy_o,
  input  logic [XLEN-1:0] exu2ialu_main_op1_i,
  input  logic [XLEN-1:0] exu2ialu_main_op2_i,
  input  logic [4:0]      exu2ialu_cmd_i,
  output logic [XLEN-1:0] ialu2exu_main_res_o,
  output logic            ialu2exu_cmp_res_o,
  input  logic [XLEN-1:0] exu2ialu_addr_op1_i,
  input  logic [XLEN-1:0] exu2ialu_addr_op2_i,
  output logic [XLEN-1:0] ialu2exu_addr_res_o
);

  typedef enum logic [4:0] {
    CMD_NONE    = 5'd0,  CMD_AND     = 5'd1,  CMD_OR      = 5'd2,  CMD_XOR  = 5'd3,
    CMD_ADD     = 5'd4,  CMD_SUB     = 5'd5,  CMD_SUB_LT  = 5'd6,  CMD_SUB_LTU = 5'd7,
    CMD_SUB_EQ  = 5'd8,  CMD_SUB_NE  = 5'd9,  CMD_SUB_GE  = 5'd10, CMD_SUB_GEU = 5'd11,
    CMD_SLL     = 5'd12, CMD_SRL     = 5'd13, CMD_SRA     = 5'd14,
    CMD_MUL     = 5'd15, CMD_MULH    = 5'd16, CMD_MULHSU  = 5'd17, CMD_MULHU = 5'd18,
    CMD_DIV     = 5'd19, CMD_DIVU    = 5'd20, CMD_REM     = 5'd21, CMD_REMU  = 5'd22
  } cmd_e;

  cmd_e            cmd;
  logic [XLEN-1:0] op1;
  logic [XLEN-1:0] op2;
  logic [XLEN-1:0] rvm_res;
  logic            rvm_rdy;

  assign cmd = cmd_e'(exu2ialu_cmd_i);
  assign op1 = exu2ialu_main_op1_i;
  assign op2 = exu2ialu_main_op2_i;

  assign ialu2exu_addr_res_o    = exu2ialu_addr_op1_i + exu2ialu_addr_op2_i;
  assign ialu2exu_rvm_res_rdy_o = rvm_rdy;

`ifdef SCR1_IALU_RVM_EN
  typedef enum logic {ST_IDLE, ST_DIV} state_e;

  state_e            state_q, state_d;
  logic [4:0]        cnt_q, cnt_d;
  logic [XLEN-1:0]   rem_q, rem_d;
  logic [XLEN-1:0]   quo_q, quo_d;
  logic [XLEN-1:0]   dvs_q, dvs_d;
  logic              negq_q, negq_d;
  logic              negr_q, negr_d;

  logic              is_mul, is_div, is_sdiv, is_rem, div_rdy;
  logic signed [2*XLEN+1:0] mul_prod;
  logic              unused_prod;
  logic [XLEN:0]     shifted, sub;
  logic              ge;
  logic [XLEN-1:0]   rem_step, quo_step, q_fin, r_fin;

  assign is_mul  = (cmd == CMD_MUL) || (cmd == CMD_MULH) || (cmd == CMD_MULHSU) || (cmd == CMD_MULHU);
  assign is_div  = (cmd == CMD_DIV) || (cmd == CMD_DIVU) || (cmd == CMD_REM) || (cmd == CMD_REMU);
  assign is_sdiv = (cmd == CMD_DIV) || (cmd == CMD_REM);
  assign is_rem  = (cmd == CMD_REM) || (cmd == CMD_REMU);

  // Operands widened to 33 bits so one signed multiplier covers all four MUL variants.
  assign mul_prod = $signed({(cmd != CMD_MULHU) & op1[XLEN-1], op1}) *
                    $signed({(cmd == CMD_MUL || cmd == CMD_MULH) & op2[XLEN-1], op2});
  assign unused_prod = ^mul_prod[2*XLEN+1:2*XLEN];

  // The final restoring step is taken combinationally so the result is valid in the ready cycle.
  assign shifted  = {rem_q, quo_q[XLEN-1]};
  assign ge       = shifted >= {1'b0, dvs_q};
  assign sub      = shifted - {1'b0, dvs_q};
  assign rem_step = ge ? sub[XLEN-1:0] : shifted[XLEN-1:0];
  assign quo_step = {quo_q[XLEN-2:0], ge};
  assign q_fin    = (dvs_q == '0) ? '1 : (negq_q ? -quo_step : quo_step);
  assign r_fin    = negr_q ? -rem_step : rem_step;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    rem_d   = rem_q;
    quo_d   = quo_q;
    dvs_d   = dvs_q;
    negq_d  = negq_q;
    negr_d  = negr_q;
    div_rdy = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (exu2ialu_rvm_cmd_vd_i && is_div) begin
          state_d = ST_DIV;
          cnt_d   = '0;
          rem_d   = '0;
          quo_d   = (is_sdiv && op1[XLEN-1]) ? -op1 : op1;
          dvs_d   = (is_sdiv && op2[XLEN-1]) ? -op2 : op2;
          negq_d  = is_sdiv && (op1[XLEN-1] ^ op2[XLEN-1]);
          negr_d  = is_sdiv && op1[XLEN-1];
        end
      end
      ST_DIV: begin
        if (!(exu2ialu_rvm_cmd_vd_i && is_div)) begin
          state_d = ST_IDLE;
          cnt_d   = '0;
        end else begin
          rem_d = rem_step;
          quo_d = quo_step;
          cnt_d = cnt_q + 5'd1;
          if (cnt_q == 5'd31) begin
            state_d = ST_IDLE;
            div_rdy = 1'b1;
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      rem_q   <= '0;
      quo_q   <= '0;
      dvs_q   <= '0;
      negq_q  <= 1'b0;
      negr_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      rem_q   <= rem_d;
      quo_q   <= quo_d;
      dvs_q   <= dvs_d;
      negq_q  <= negq_d;
      negr_q  <= negr_d;
    end
  end

  always_comb begin
    rvm_rdy = 1'b0;
    rvm_res = '0;
    if (exu2ialu_rvm_cmd_vd_i && is_mul) begin
      rvm_rdy = 1'b1;
      rvm_res = (cmd == CMD_MUL) ? mul_prod[XLEN-1:0] : mul_prod[2*XLEN-1:XLEN];
    end else if (div_rdy) begin
      rvm_rdy = 1'b1;
      rvm_res = is_rem ? r_fin : q_fin;
    end
  end
`else
  logic unused_clk_rst;
  assign unused_clk_rst = clk ^ rst;
  assign rvm_rdy        = 1'b0;
  assign rvm_res        = '0;
`endif

  always_comb begin
    ialu2exu_main_res_o = '0;
    ialu2exu_cmp_res_o  = 1'b0;
    case (cmd)
      CMD_AND:     ialu2exu_main_res_o = op1 & op2;
      CMD_OR:      ialu2exu_main_res_o = op1 | op2;
      CMD_XOR:     ialu2exu_main_res_o = op1 ^ op2;
      CMD_ADD:     ialu2exu_main_res_o = op1 + op2;
      CMD_SUB:     ialu2exu_main_res_o = op1 - op2;
      CMD_SUB_LT:  ialu2exu_cmp_res_o  = $signed(op1) < $signed(op2);
      CMD_SUB_LTU: ialu2exu_cmp_res_o  = op1 < op2;
      CMD_SUB_EQ:  ialu2exu_cmp_res_o  = op1 == op2;
      CMD_SUB_NE:  ialu2exu_cmp_res_o  = op1 != op2;
      CMD_SUB_GE:  ialu2exu_cmp_res_o  = $signed(op1) >= $signed(op2);
      CMD_SUB_GEU: ialu2exu_cmp_res_o  = op1 >= op2;
      CMD_SLL:     ialu2exu_main_res_o = op1 << op2[4:0];
      CMD_SRL:     ialu2exu_main_res_o = op1 >> op2[4:0];
      CMD_SRA:     ialu2exu_main_res_o = $signed(op1) >>> op2[4:0];
      CMD_MUL, CMD_MULH, CMD_MULHSU, CMD_MULHU,
      CMD_DIV, CMD_DIVU, CMD_REM, CMD_REMU:
                   ialu2exu_main_res_o = rvm_res;
      default:     ialu2exu_main_res_o = '0;
    endcase
    if (cmd >= CMD_SUB_LT && cmd <= CMD_SUB_GEU)
      ialu2exu_main_res_o = {{(XLEN-1){1'b0}}, ialu2exu_cmp_res_o};
  end

endmodule

// File: tb/tb_pipe_ialu.sv
// Self-checking bench for pipe_ialu: directed vector table, random main-ALU traffic against a
// behavioural model, and (with SCR1_IALU_RVM_EN) MUL/DIV latency, boundary and abort sequences.
module tb_pipe_ialu;

  typedef enum logic [4:0] {
    C_NONE = 5'd0, C_AND = 5'd1, C_OR = 5'd2, C_XOR = 5'd3, C_ADD = 5'd4, C_SUB = 5'd5,
    C_LT = 5'd6, C_LTU = 5'd7, C_EQ = 5'd8, C_NE = 5'd9, C_GE = 5'd10, C_GEU = 5'd11,
    C_SLL = 5'd12, C_SRL = 5'd13, C_SRA = 5'd14,
    C_MUL = 5'd15, C_MULH = 5'd16, C_MULHSU = 5'd17, C_MULHU = 5'd18,
    C_DIV = 5'd19, C_DIVU = 5'd20, C_REM = 5'd21, C_REMU = 5'd22
  } tcmd_e;

  typedef struct {
    logic [4:0]  cmd;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] exp_res;
    logic        exp_cmp;
  } vec_t;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        vd  = 1'b0;
  logic        rdy;
  logic [31:0] op1 = '0, op2 = '0, res, aop1 = '0, aop2 = '0, ares;
  logic [4:0]  cmd = '0;
  logic        cmp;

  int unsigned checks = 0;
  int unsigned failures = 0;
  vec_t        vecs[$];

  pipe_ialu #(.XLEN(32)) dut (
    .clk                    (clk),
    .rst                    (rst),
    .exu2ialu_rvm_cmd_vd_i  (vd),
    .ialu2exu_rvm_res_rdy_o (rdy),
    .exu2ialu_main_op1_i    (op1),
    .exu2ialu_main_op2_i    (op2),
    .exu2ialu_cmd_i         (cmd),
    .ialu2exu_main_res_o    (res),
    .ialu2exu_cmp_res_o     (cmp),
    .exu2ialu_addr_op1_i    (aop1),
    .exu2ialu_addr_op2_i    (aop2),
    .ialu2exu_addr_res_o    (ares)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s got=%h exp=%h", nm, act, exp);
    end
  endtask

  function automatic void add_vec(input logic [4:0] c, input logic [31:0] a, input logic [31:0] b,
                                  input logic [31:0] r, input logic f);
    vec_t v;
    v.cmd = c; v.a = a; v.b = b; v.exp_res = r; v.exp_cmp = f;
    vecs.push_back(v);
  endfunction

  // Reference: main-ALU semantics from the instruction definitions (RVM codes with vd=0 give 0).
  function automatic void ref_main(input logic [4:0] c, input logic [31:0] a, input logic [31:0] b,
                                   output logic [31:0] r, output logic f);
    int sa, sb;
    sa = $signed(a); sb = $signed(b);
    r = 32'h0; f = 1'b0;
    case (c)
      5'd1: r = a & b;
      5'd2: r = a | b;
      5'd3: r = a ^ b;
      5'd4: r = a + b;
      5'd5: r = a - b;
      5'd6: f = sa < sb;
      5'd7: f = a < b;
      5'd8: f = a == b;
      5'd9: f = a != b;
      5'd10: f = sa >= sb;
      5'd11: f = a >= b;
      5'd12: r = a << (b % 32);
      5'd13: r = a >> (b % 32);
      5'd14: r = sa >>> (b % 32);
      default: r = 32'h0;
    endcase
    if (c >= 5'd6 && c <= 5'd11) r = {31'h0, f};
  endfunction

  function automatic logic [31:0] ref_mul(input logic [4:0] c, input logic [31:0] a, input logic [31:0] b);
    longint          ss, su;
    longint unsigned uu;
    ss = longint'($signed(a)) * longint'($signed(b));
    su = longint'($signed(a)) * longint'({32'h0, b});
    uu = {32'h0, a} * {32'h0, b};
    case (c)
      5'd15: return ss[31:0];
      5'd16: return ss[63:32];
      5'd17: return su[63:32];
      default: return uu[63:32];
    endcase
  endfunction

  function automatic logic [31:0] ref_div(input logic [4:0] c, input logic [31:0] a, input logic [31:0] b);
    int sa, sb;
    sa = $signed(a); sb = $signed(b);
    if (b == 32'h0) return (c == 5'd21 || c == 5'd22) ? a : 32'hFFFF_FFFF;
    if ((c == 5'd19 || c == 5'd21) && a == 32'h8000_0000 && b == 32'hFFFF_FFFF)
      return (c == 5'd19) ? 32'h8000_0000 : 32'h0;
    case (c)
      5'd19: return sa / sb;
      5'd20: return a / b;
      5'd21: return sa % sb;
      default: return a % b;
    endcase
  endfunction

`ifdef SCR1_IALU_RVM_EN
  task automatic run_div(input string nm, input logic [4:0] c, input logic [31:0] a, input logic [31:0] b);
    int unsigned lat;
    @(posedge clk); #1;
    vd = 1'b1; cmd = c; op1 = a; op2 = b;
    #1;
    chk({nm, "_rdy_accept"}, {31'h0, rdy}, 32'h0);
    @(posedge clk); #1;
    lat = 1;
    while (!rdy && lat < 40) begin
      chk({nm, "_res_busy"}, res, 32'h0);
      @(posedge clk); #1;
      lat++;
    end
    chk({nm, "_latency"}, lat, 32'd32);
    chk({nm, "_res"}, res, ref_div(c, a, b));
    @(posedge clk); #1;
    vd = 1'b0;
    #1;
    chk({nm, "_rdy_after"}, {31'h0, rdy}, 32'h0);
  endtask
`endif

  initial begin
    logic [31:0] er;
    logic        ef;

    // Reset with a pending divide request: nothing may be reported ready.
    vd = 1'b1; cmd = 5'd19; op1 = 32'd100; op2 = 32'd3;
    repeat (3) @(posedge clk);
    #1;
    chk("reset_rdy", {31'h0, rdy}, 32'h0);
    chk("reset_res", res, 32'h0);
    vd = 1'b0; cmd = 5'd0;
    @(posedge clk); #1;
    rst = 1'b0;

    add_vec(C_ADD, 32'hFFFF_FFFF, 32'h1,         32'h0,         1'b0);
    add_vec(C_SUB, 32'h0,         32'h1,         32'hFFFF_FFFF, 1'b0);
    add_vec(C_LT,  32'hFFFF_FFFF, 32'h1,         32'h1,         1'b1);
    add_vec(C_LTU, 32'hFFFF_FFFF, 32'h1,         32'h0,         1'b0);
    add_vec(C_EQ,  32'd5,         32'd5,         32'h1,         1'b1);
    add_vec(C_NE,  32'd5,         32'd5,         32'h0,         1'b0);
    add_vec(C_GEU, 32'h0,         32'h0,         32'h1,         1'b1);
    add_vec(C_GE,  32'h8000_0000, 32'h7FFF_FFFF, 32'h0,         1'b0);
    add_vec(C_SRA, 32'h8000_0000, 32'h24,        32'hF800_0000, 1'b0);
    add_vec(C_SRL, 32'h8000_0000, 32'h24,        32'h0800_0000, 1'b0);
    add_vec(C_SLL, 32'h1,         32'd31,        32'h8000_0000, 1'b0);
    add_vec(C_AND, 32'hF0F0_F0F0, 32'hFF00_FF00, 32'hF000_F000, 1'b0);
    add_vec(C_OR,  32'hF0F0_F0F0, 32'hFF00_FF00, 32'hFFF0_FFF0, 1'b0);
    add_vec(C_XOR, 32'hF0F0_F0F0, 32'hFF00_FF00, 32'h0FF0_0FF0, 1'b0);
    add_vec(C_NONE, 32'h1234,     32'h5678,      32'h0,         1'b0);
    add_vec(5'd31, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0,         1'b0);

    foreach (vecs[i]) begin
      cmd = vecs[i].cmd; op1 = vecs[i].a; op2 = vecs[i].b;
      #1;
      chk($sformatf("vec%0d_res", i), res, vecs[i].exp_res);
      chk($sformatf("vec%0d_cmp", i), {31'h0, cmp}, {31'h0, vecs[i].exp_cmp});
    end

    aop1 = 32'h1000; aop2 = 32'hFFFF_FFFC;
    #1;
    chk("addr_wrap", ares, 32'h0000_0FFC);

    // Random main-ALU and address traffic; RVM codes are idle here so they must read as zero.
    for (int i = 0; i < 2000; i++) begin
      cmd  = 5'($urandom_range(0, 31));
      op1  = $urandom;
      op2  = ($urandom_range(0, 7) == 0) ? op1 : $urandom;
      aop1 = $urandom; aop2 = $urandom;
      ref_main(cmd, op1, op2, er, ef);
      #1;
      chk("rnd_res", res, er);
      chk("rnd_cmp", {31'h0, cmp}, {31'h0, ef});
      chk("rnd_addr", ares, aop1 + aop2);
      chk("rnd_rdy", {31'h0, rdy}, 32'h0);
    end

`ifdef SCR1_IALU_RVM_EN
    vd = 1'b1; cmd = C_MULH; op1 = 32'h8000_0000; op2 = 32'h8000_0000;
    #1;
    chk("mulh_min_res", res, 32'h4000_0000);
    chk("mulh_min_rdy", {31'h0, rdy}, 32'h1);
    cmd = C_MULHU; op1 = 32'hFFFF_FFFF; op2 = 32'hFFFF_FFFF;
    #1;
    chk("mulhu_max_res", res, 32'hFFFF_FFFE);
    for (int i = 0; i < 300; i++) begin
      cmd = 5'($urandom_range(15, 18));
      op1 = $urandom; op2 = $urandom;
      #1;
      chk("rnd_mul_res", res, ref_mul(cmd, op1, op2));
      chk("rnd_mul_rdy", {31'h0, rdy}, 32'h1);
    end
    vd = 1'b0; cmd = C_NONE;

    run_div("div_m7_2", C_DIV, 32'hFFFF_FFF9, 32'd2);
    run_div("rem_m7_2", C_REM, 32'hFFFF_FFF9, 32'd2);
    run_div("divu_7_0", C_DIVU, 32'd7, 32'd0);
    run_div("rem_7_0",  C_REM, 32'd7, 32'd0);
    run_div("div_ovf",  C_DIV, 32'h8000_0000, 32'hFFFF_FFFF);
    run_div("rem_ovf",  C_REM, 32'h8000_0000, 32'hFFFF_FFFF);
    run_div("div_m7_0", C_DIV, 32'hFFFF_FFF9, 32'd0);
    for (int i = 0; i < 8; i++)
      run_div("div_rnd", 5'($urandom_range(19, 22)), $urandom, $urandom_range(1, 1000));

    // vd dropped mid-division, then a fresh divide must complete with full latency.
    @(posedge clk); #1;
    vd = 1'b1; cmd = C_DIV; op1 = 32'd1000; op2 = 32'd7;
    repeat (11) @(posedge clk);
    #1;
    vd = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(posedge clk); #1;
      chk("abort_vd_rdy", {31'h0, rdy}, 32'h0);
    end
    run_div("after_vd_abort", C_DIVU, 32'd1000, 32'd7);

    // Reset mid-division with vd still high: reset wins, then the held request restarts cleanly.
    @(posedge clk); #1;
    vd = 1'b1; cmd = C_REM; op1 = 32'hFFFF_FC18; op2 = 32'd7;
    repeat (11) @(posedge clk);
    #1;
    rst = 1'b1;
    @(posedge clk); #1;
    chk("abort_rst_rdy", {31'h0, rdy}, 32'h0);
    rst = 1'b0; vd = 1'b0;
    @(posedge clk); #1;
    chk("abort_rst_idle", {31'h0, rdy}, 32'h0);
    run_div("after_rst_abort", C_REM, 32'hFFFF_FC18, 32'd7);
`else
    for (int c = 15; c <= 22; c++) begin
      vd = 1'b1; cmd = 5'(c); op1 = $urandom; op2 = $urandom;
      repeat (2) @(posedge clk);
      #1;
      chk("rvm_off_res", res, 32'h0);
      chk("rvm_off_rdy", {31'h0, rdy}, 32'h0);
    end
    vd = 1'b0;
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #5_000_000;
    $display("FAIL timeout got=running exp=finished");
    $fatal(1, "timeout");
  end

endmodule
